display_scan_controller: RTL and testbench

- Sequences the 4-digit multiplexed seven-segment display from a 16-bit packed BCD frame.
- Drives the active-low digit selects and segments, with an inter-digit blanking gap to prevent ghosting, leading-zero suppression and 8-level brightness.
- Sits between the binary-to-BCD converter and the display pins, clocked from the 50 MHz board clock.

---
 rtl/display_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scanner: BLANK gap then ON dwell per digit,
// frame-latched BCD, leading-zero suppression and 8-level brightness via dwell duty.
module display_scan_controller #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        CLOCK_50_MHz,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic [2:0]  brightness,
    input  logic        lz_suppress,
    output logic [6:0]  display,
    output logic [3:0]  dis_sel,
    output logic        digit_strobe,
    output logic        frame_done
);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW+3:0]   STEP       = (CW+4)'(DWELL_CYCLES / 8);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   bcd_q;
    logic [2:0]    bright_q;
    logic          lz_q;
    logic          latch_en;
    logic [6:0]    disp_q, disp_d;
    logic [3:0]    sel_q, sel_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic [3:0]    digit;
    logic [3:0]    supp;
    logic [CW+3:0] lit_limit;
    logic          lit;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    // Digit n is suppressed only when it and every higher digit are zero.
    always_comb begin
        digit     = bcd_q[{idx_q, 2'b00} +: 4];
        supp[3]   = lz_q && (bcd_q[15:12] == 4'd0);
        supp[2]   = lz_q && (bcd_q[15:8] == 8'd0);
        supp[1]   = lz_q && (bcd_q[15:4] == 12'd0);
        supp[0]   = 1'b0;
        lit_limit = ((CW+4)'(bright_q) + (CW+4)'(1)) * STEP;
        lit       = ((CW+4)'(cnt_q) < lit_limit);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        disp_d   = 7'h7F;
        sel_d    = 4'hF;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    idx_d    = 2'd0;
                    cnt_d    = '0;
                    latch_en = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ON: begin
                    strobe_d = (cnt_q == '0);
                    done_d   = (cnt_q == DWELL_LAST) && (idx_q == 2'd3);
                    if (lit) begin
                        sel_d  = ~(4'b0001 << idx_q);
                        disp_d = supp[idx_q] ? 7'h7F : seg7(digit);
                    end
                    if (cnt_q == DWELL_LAST) begin
                        state_d  = BLANK;
                        cnt_d    = '0;
                        idx_d    = idx_q + 2'd1;
                        latch_en = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50_MHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge CLOCK_50_MHz or posedge reset) begin
        if (reset) begin
            bcd_q    <= 16'h0000;
            bright_q <= 3'd0;
            lz_q     <= 1'b0;
        end else if (latch_en) begin
            bcd_q    <= bcd_in;
            bright_q <= brightness;
            lz_q     <= lz_suppress;
        end
    end

    // Output stage registers the current state's view, so select and segments move together.
    always_ff @(posedge CLOCK_50_MHz or posedge reset) begin
        if (reset) begin
            disp_q   <= 7'h7F;
            sel_q    <= 4'hF;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            disp_q   <= disp_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign display      = disp_q;
    assign dis_sel      = sel_q;
    assign digit_strobe = strobe_q;
    assign frame_done   = done_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: vector table, corner sequences, random run vs timeline model.
module tb_display_scan_controller;
    localparam int D = 16;
    localparam int B = 2;
    localparam int P = 4 * (B + D);

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] bcd;
    logic [2:0]  br;
    logic        lz;
    logic [6:0]  disp;
    logic [3:0]  sel;
    logic        strobe;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cur;
    int rk;
    logic [15:0] m_bcd;
    logic [2:0]  m_br;
    logic        m_lz;
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    display_scan_controller #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .CLOCK_50_MHz(clk), .reset(rst), .enable(en), .bcd_in(bcd),
        .brightness(br), .lz_suppress(lz), .display(disp), .dis_sel(sel),
        .digit_strobe(strobe), .frame_done(done)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [2:0]  br;
        logic        lz;
        int          n;
        logic [6:0]  disp;
        logic [3:0]  sel;
        logic        stb;
        logic        fd;
    } vec_t;
    vec_t vecs [16];

    localparam logic [12:0] DARK = {7'h7F, 4'hF, 1'b0, 1'b0};

    function automatic logic [12:0] outs();
        return {disp, sel, strobe, done};
    endfunction

    task automatic check(input string nm, input logic [12:0] got, input logic [12:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got disp=%b sel=%b stb=%b fd=%b, expected disp=%b sel=%b stb=%b fd=%b",
                     nm, got[12:6], got[5:2], got[1], got[0], exp[12:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Expected outputs rk edges after the enable-sampling edge, from the frame timeline.
    function automatic logic [12:0] model_out(input int k);
        int pos, slot, off, dw;
        logic [6:0] d;
        logic [3:0] s;
        logic [3:0] nib;
        logic st, fd;
        d = 7'h7F; s = 4'hF; st = 1'b0; fd = 1'b0;
        if (k > 0) begin
            pos  = (k - 1) % P;
            slot = pos / (B + D);
            off  = pos % (B + D);
            if (off >= B) begin
                dw = off - B;
                st = (dw == 0);
                fd = (slot == 3) && (dw == D - 1);
                if (dw < (int'(m_br) + 1) * D / 8) begin
                    s[slot] = 1'b0;
                    nib = 4'(m_bcd >> (4 * slot));
                    if (m_lz && slot > 0 && (m_bcd >> (4 * slot)) == 16'd0) d = 7'h7F;
                    else d = seg_tab[nib];
                end
            end
        end
        return {d, s, st, fd};
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic start(input logic [15:0] b, input logic [2:0] r, input logic z);
        rst = 1'b1; en = 1'b0; bcd = b; br = r; lz = z;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        cur = -1;
    endtask

    task automatic goto(input int n);
        repeat (n - cur) @(posedge clk);
        #1;
        cur = n;
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

        vecs[0]  = '{16'h1234, 3'd7, 1'b0,  3, 7'b0011001, 4'b1110, 1'b1, 1'b0};
        vecs[1]  = '{16'h1234, 3'd7, 1'b0,  2, 7'h7F,      4'hF,    1'b0, 1'b0};
        vecs[2]  = '{16'h1234, 3'd7, 1'b0, 18, 7'b0011001, 4'b1110, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 3'd7, 1'b0, 19, 7'h7F,      4'hF,    1'b0, 1'b0};
        vecs[4]  = '{16'h1234, 3'd7, 1'b0, 21, 7'b0110000, 4'b1101, 1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 3'd7, 1'b0, 39, 7'b0100100, 4'b1011, 1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 3'd7, 1'b0, 57, 7'b1111001, 4'b0111, 1'b1, 1'b0};
        vecs[7]  = '{16'h1234, 3'd7, 1'b0, 72, 7'b1111001, 4'b0111, 1'b0, 1'b1};
        vecs[8]  = '{16'h1234, 3'd0, 1'b0,  4, 7'b0011001, 4'b1110, 1'b0, 1'b0};
        vecs[9]  = '{16'h1234, 3'd0, 1'b0,  5, 7'h7F,      4'hF,    1'b0, 1'b0};
        vecs[10] = '{16'h1234, 3'd3, 1'b0, 10, 7'b0011001, 4'b1110, 1'b0, 1'b0};
        vecs[11] = '{16'h1234, 3'd3, 1'b0, 11, 7'h7F,      4'hF,    1'b0, 1'b0};
        vecs[12] = '{16'h0007, 3'd7, 1'b1,  3, 7'b1111000, 4'b1110, 1'b1, 1'b0};
        vecs[13] = '{16'h0007, 3'd7, 1'b1, 21, 7'h7F,      4'b1101, 1'b1, 1'b0};
        vecs[14] = '{16'h0000, 3'd7, 1'b1,  3, 7'b1000000, 4'b1110, 1'b1, 1'b0};
        vecs[15] = '{16'h0A00, 3'd7, 1'b0, 39, 7'b0111111, 4'b1011, 1'b1, 1'b0};

        rst = 1'b0; en = 1'b0; bcd = '0; br = '0; lz = 1'b0;
        #1 rst = 1'b1;
        #2 check("reset_state", outs(), DARK);

        for (int i = 0; i < 16; i++) begin
            start(vecs[i].bcd, vecs[i].br, vecs[i].lz);
            goto(vecs[i].n);
            check($sformatf("vec%0d", i), outs(), {vecs[i].disp, vecs[i].sel, vecs[i].stb, vecs[i].fd});
        end

        // suppression stops at a nonzero higher digit; dash digit is never a zero
        start(16'h1034, 3'd7, 1'b1);
        goto(39); check("lz_inner_zero", outs(), {7'b1000000, 4'b1011, 1'b1, 1'b0});
        start(16'h0A00, 3'd7, 1'b1);
        goto(39); check("lz_dash", outs(), {7'b0111111, 4'b1011, 1'b1, 1'b0});
        goto(57); check("lz_top_zero", outs(), {7'h7F, 4'b0111, 1'b1, 1'b0});

        // mid-frame input change only takes effect next frame
        start(16'h1234, 3'd7, 1'b0);
        goto(25);
        @(negedge clk); bcd = 16'h5678;
        goto(39); check("latch_d2", outs(), {7'b0100100, 4'b1011, 1'b1, 1'b0});
        goto(57); check("latch_d3", outs(), {7'b1111001, 4'b0111, 1'b1, 1'b0});
        goto(75); check("next_d0",  outs(), {7'b0000000, 4'b1110, 1'b1, 1'b0});
        goto(93); check("next_d1",  outs(), {7'b1111000, 4'b1101, 1'b1, 1'b0});

        // enable drop mid-ON of digit2, then restart
        start(16'h1234, 3'd7, 1'b0);
        goto(45); check("pre_drop", outs(), {7'b0100100, 4'b1011, 1'b0, 1'b0});
        @(negedge clk); en = 1'b0;
        for (int i = 46; i < 80; i++) begin
            goto(i);
            check("dropped_dark", outs(), DARK);
        end
        @(negedge clk); en = 1'b1; cur = -1;
        goto(2); check("reen_blank", outs(), DARK);
        goto(3); check("reen_d0", outs(), {7'b0011001, 4'b1110, 1'b1, 1'b0});

        // async reset mid-ON
        start(16'h1234, 3'd7, 1'b0);
        goto(21);
        #2 rst = 1'b1;
        #1 check("async_rst_on", outs(), DARK);
        // reset mid-BLANK, release with enable high
        start(16'h1234, 3'd7, 1'b0);
        goto(37);
        #2 rst = 1'b1;
        #1 check("async_rst_blank", outs(), DARK);
        @(negedge clk); rst = 1'b0; cur = -1;
        goto(2);  check("rst_restart_blank", outs(), DARK);
        goto(3);  check("rst_restart_d0", outs(), {7'b0011001, 4'b1110, 1'b1, 1'b0});
        goto(21); check("rst_restart_d1", outs(), {7'b0110000, 4'b1101, 1'b1, 1'b0});

        // randomized run against the timeline model
        rst = 1'b1; en = 1'b0; bcd = rand_bcd(); br = 3'd7; lz = 1'b0;
        @(negedge clk); rst = 1'b0;
        rk = -1; m_bcd = '0; m_br = '0; m_lz = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            logic [12:0] exp;
            @(negedge clk);
            en = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 39) == 0) bcd = rand_bcd();
            if ($urandom_range(0, 99) == 0) br = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) lz = ~lz;
            @(posedge clk);
            if (!en) begin
                rk = -1;
                exp = DARK;
            end else if (rk < 0) begin
                rk = 0;
                exp = DARK;
                m_bcd = bcd; m_br = br; m_lz = lz;
            end else begin
                rk++;
                exp = model_out(rk);
                if (rk % P == 0) begin
                    m_bcd = bcd; m_br = br; m_lz = lz;
                end
            end
            #1 check("random", outs(), exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
